// File: rtl/pc_fetch_unit_if.sv
// Fetch-unit bus: ADD4 loop, redirect inputs, imem handshake and decode-side outputs.
// The fetch unit connects through the master modport; its environment uses slave.
interface pc_fetch_unit_if;
  logic [31:0] pc_plus4;
  logic [31:0] pc_out;
  logic        jmp;
  logic [31:0] jmp_target;
  logic        br_taken;
  logic [31:0] br_target;
  logic        stall;
  logic        imem_req;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic        misalign;
  logic        add4_err;

  modport master (
    input  pc_plus4, jmp, jmp_target, br_taken, br_target, stall, imem_ack, imem_rdata,
    output pc_out, imem_req, instr, instr_valid, misalign, add4_err
  );

  modport slave (
    output pc_plus4, jmp, jmp_target, br_taken, br_target, stall, imem_ack, imem_rdata,
    input  pc_out, imem_req, instr, instr_valid, misalign, add4_err
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// Program counter and one-outstanding instruction-fetch sequencer.
// Optional macro PC_CHECK_EN builds a sticky checker of the external ADD4 result.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic            clk,
  input logic            rst,
  pc_fetch_unit_if.master bus
);

  typedef enum logic [1:0] {S_BOOT, S_REQ, S_HOLD} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pend_target_q, pend_target_d;
  logic        pend_valid_q, pend_valid_d;
  logic        imem_req_q, imem_req_d;
  logic        instr_valid_q, instr_valid_d;
  logic        misalign_q, misalign_d;

  logic        redir;
  logic        redir_misaligned;
  logic [31:0] raw_target;
  logic [31:0] redir_target;

  always_comb begin
    redir            = bus.jmp | bus.br_taken;
    raw_target       = bus.jmp ? bus.jmp_target : bus.br_target;
    redir_target     = {raw_target[31:2], 2'b00};
    redir_misaligned = redir && (raw_target[1:0] != 2'b00);

    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    pend_target_d = pend_target_q;
    pend_valid_d  = pend_valid_q;
    misalign_d    = 1'b0;

    case (state_q)
      S_BOOT: state_d = S_REQ;
      S_REQ: begin
        misalign_d = redir_misaligned;
        if (!bus.imem_ack) begin
          if (redir) begin
            pend_valid_d  = 1'b1;
            pend_target_d = redir_target;
          end
        end else if (redir) begin
          pc_d         = redir_target;
          pend_valid_d = 1'b0;
        end else if (pend_valid_q) begin
          pc_d         = pend_target_q;
          pend_valid_d = 1'b0;
        end else begin
          instr_d = bus.imem_rdata;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        misalign_d = redir_misaligned;
        if (redir) begin
          pc_d    = redir_target;
          state_d = S_REQ;
        end else if (!bus.stall) begin
          pc_d    = bus.pc_plus4;
          state_d = S_REQ;
        end
      end
      default: state_d = S_BOOT;
    endcase

    // Request and valid flags are registered views of the next state.
    imem_req_d    = (state_d == S_REQ);
    instr_valid_d = (state_d == S_HOLD);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_BOOT;
      pc_q          <= RESET_PC;
      instr_q       <= 32'h0;
      pend_target_q <= 32'h0;
      pend_valid_q  <= 1'b0;
      imem_req_q    <= 1'b0;
      instr_valid_q <= 1'b0;
      misalign_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      pend_target_q <= pend_target_d;
      pend_valid_q  <= pend_valid_d;
      imem_req_q    <= imem_req_d;
      instr_valid_q <= instr_valid_d;
      misalign_q    <= misalign_d;
    end
  end

  assign bus.pc_out      = pc_q;
  assign bus.imem_req    = imem_req_q;
  assign bus.instr       = instr_q;
  assign bus.instr_valid = instr_valid_q;
  assign bus.misalign    = misalign_q;

`ifdef PC_CHECK_EN
  logic [31:0] pc_expect;
  logic        add4_err_q, add4_err_d;

  always_comb begin
    pc_expect  = pc_q + 32'd4;
    add4_err_d = add4_err_q | (bus.pc_plus4 != pc_expect);
  end

  always_ff @(posedge clk) begin
    if (rst) add4_err_q <= 1'b0;
    else     add4_err_q <= add4_err_d;
  end

  assign bus.add4_err = add4_err_q;
`else
  assign bus.add4_err = 1'b0;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: vector table plus hand sequences for reset abort,
// PC wrap-around (second instance) and the ADD4 checker.
module tb_pc_fetch_unit;

  typedef struct {
    logic        jmp;
    logic [31:0] jmpTarget;
    logic        br;
    logic [31:0] brTarget;
    logic        stall;
    logic        ack;
    logic [31:0] rdata;
    logic [31:0] expPc;
    logic        expReq;
    logic [31:0] expInstr;
    logic        expValid;
    logic        expMis;
  } vec_t;

`ifdef PC_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  localparam logic [31:0] A1 = 32'h2008_0005;
  localparam logic [31:0] A2 = 32'h1111_1111;
  localparam logic [31:0] A3 = 32'h2222_2222;
  localparam logic [31:0] A4 = 32'h3333_3333;
  localparam logic [31:0] A5 = 32'h4444_4444;
  localparam logic [31:0] A6 = 32'h5555_5555;
  localparam logic [31:0] A7 = 32'h6666_6666;
  localparam logic [31:0] A8 = 32'h7777_7777;

  logic clk = 1'b0;
  logic rst;
  logic add4Bad;
  int   errors = 0;
  int   checks = 0;
  vec_t vecs [29];

  always #5 clk = ~clk;

  pc_fetch_unit_if mainIf ();
  pc_fetch_unit_if wrapIf ();

  assign mainIf.pc_plus4   = mainIf.pc_out + (add4Bad ? 32'd8 : 32'd4);
  assign wrapIf.pc_plus4   = wrapIf.pc_out + 32'd4;
  assign wrapIf.jmp        = 1'b0;
  assign wrapIf.jmp_target = 32'h0;
  assign wrapIf.br_taken   = 1'b0;
  assign wrapIf.br_target  = 32'h0;
  assign wrapIf.stall      = 1'b0;
  assign wrapIf.imem_ack   = mainIf.imem_ack;
  assign wrapIf.imem_rdata = mainIf.imem_rdata;

  pc_fetch_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (mainIf.master)
  );

  pc_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dutWrap (
    .clk (clk),
    .rst (rst),
    .bus (wrapIf.master)
  );

  function automatic vec_t mk(input logic j, input logic [31:0] jt, input logic b,
                              input logic [31:0] bt, input logic s, input logic a,
                              input logic [31:0] rd, input logic [31:0] ePc, input logic eReq,
                              input logic [31:0] eInstr, input logic eValid, input logic eMis);
    vec_t v;
    v.jmp = j; v.jmpTarget = jt; v.br = b; v.brTarget = bt; v.stall = s; v.ack = a;
    v.rdata = rd; v.expPc = ePc; v.expReq = eReq; v.expInstr = eInstr;
    v.expValid = eValid; v.expMis = eMis;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input vec_t v);
    mainIf.jmp        = v.jmp;
    mainIf.jmp_target = v.jmpTarget;
    mainIf.br_taken   = v.br;
    mainIf.br_target  = v.brTarget;
    mainIf.stall      = v.stall;
    mainIf.imem_ack   = v.ack;
    mainIf.imem_rdata = v.rdata;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic checkMain(input string tag, input logic [31:0] ePc, input logic eReq,
                           input logic [31:0] eInstr, input logic eValid, input logic eMis,
                           input logic eErr);
    checkOutput({tag, " pc_out"},      mainIf.pc_out,             ePc);
    checkOutput({tag, " imem_req"},    {31'h0, mainIf.imem_req},    {31'h0, eReq});
    checkOutput({tag, " instr"},       mainIf.instr,              eInstr);
    checkOutput({tag, " instr_valid"}, {31'h0, mainIf.instr_valid}, {31'h0, eValid});
    checkOutput({tag, " misalign"},    {31'h0, mainIf.misalign},    {31'h0, eMis});
    checkOutput({tag, " add4_err"},    {31'h0, mainIf.add4_err},    {31'h0, eErr});
  endtask

  task automatic idleInputs();
    applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
  endtask

  initial begin
    vecs[0]  = mk(0, 0,     0, 0,     0, 1, A1,           32'h000, 1, 32'h0, 0, 0);
    vecs[1]  = mk(0, 0,     0, 0,     0, 1, A1,           32'h000, 0, A1,    1, 0);
    vecs[2]  = mk(0, 0,     0, 0,     0, 1, A2,           32'h004, 1, A1,    0, 0);
    vecs[3]  = mk(0, 0,     0, 0,     0, 1, A2,           32'h004, 0, A2,    1, 0);
    vecs[4]  = mk(0, 0,     0, 0,     0, 1, A3,           32'h008, 1, A2,    0, 0);
    vecs[5]  = mk(0, 0,     0, 0,     0, 1, A3,           32'h008, 0, A3,    1, 0);
    vecs[6]  = mk(0, 0,     0, 0,     1, 1, A4,           32'h008, 0, A3,    1, 0);
    vecs[7]  = mk(0, 0,     0, 0,     1, 1, A4,           32'h008, 0, A3,    1, 0);
    vecs[8]  = mk(0, 0,     0, 0,     1, 1, A4,           32'h008, 0, A3,    1, 0);
    vecs[9]  = mk(0, 0,     0, 0,     0, 1, A4,           32'h00C, 1, A3,    0, 0);
    vecs[10] = mk(0, 0,     0, 0,     0, 1, A4,           32'h00C, 0, A4,    1, 0);
    vecs[11] = mk(1, 'h100, 1, 'h40,  1, 1, A5,           32'h100, 1, A4,    0, 0);
    vecs[12] = mk(0, 0,     0, 0,     0, 1, A5,           32'h100, 0, A5,    1, 0);
    vecs[13] = mk(1, 'h103, 0, 0,     0, 1, A5,           32'h100, 1, A5,    0, 1);
    vecs[14] = mk(0, 0,     0, 0,     0, 0, A5,           32'h100, 1, A5,    0, 0);
    vecs[15] = mk(0, 0,     1, 'h80,  0, 0, A5,           32'h100, 1, A5,    0, 0);
    vecs[16] = mk(0, 0,     0, 0,     0, 0, A5,           32'h100, 1, A5,    0, 0);
    vecs[17] = mk(0, 0,     0, 0,     0, 0, A5,           32'h100, 1, A5,    0, 0);
    vecs[18] = mk(0, 0,     0, 0,     0, 1, 32'hDEADBEEF, 32'h080, 1, A5,    0, 0);
    vecs[19] = mk(0, 0,     0, 0,     0, 1, A6,           32'h080, 0, A6,    1, 0);
    vecs[20] = mk(0, 0,     1, 'h202, 0, 0, A6,           32'h200, 1, A6,    0, 1);
    vecs[21] = mk(0, 0,     1, 'h300, 0, 0, A6,           32'h200, 1, A6,    0, 0);
    vecs[22] = mk(1, 'h400, 0, 0,     0, 0, A6,           32'h200, 1, A6,    0, 0);
    vecs[23] = mk(0, 0,     0, 0,     0, 1, 32'hBAD0BAD0, 32'h400, 1, A6,    0, 0);
    vecs[24] = mk(0, 0,     1, 'h600, 0, 0, A6,           32'h400, 1, A6,    0, 0);
    vecs[25] = mk(1, 'h501, 0, 0,     0, 1, 32'hBAD1BAD1, 32'h500, 1, A6,    0, 1);
    vecs[26] = mk(0, 0,     0, 0,     0, 1, A7,           32'h500, 0, A7,    1, 0);
    vecs[27] = mk(0, 0,     0, 0,     0, 0, A7,           32'h504, 1, A7,    0, 0);
    vecs[28] = mk(0, 0,     0, 0,     0, 1, A8,           32'h504, 0, A8,    1, 0);

    add4Bad = 1'b0;
    rst     = 1'b1;
    idleInputs();
    step();
    step();
    checkMain("reset", 32'h0, 0, 32'h0, 0, 0, 0);
    checkOutput("reset wrap pc_out", wrapIf.pc_out, 32'hFFFF_FFFC);

    rst = 1'b0;
    for (int i = 0; i < 29; i++) begin
      applyStimulus(vecs[i]);
      step();
      checkMain($sformatf("vec%0d", i), vecs[i].expPc, vecs[i].expReq, vecs[i].expInstr,
                vecs[i].expValid, vecs[i].expMis, 1'b0);
    end

    // Reset in the middle of a request with a latched redirect: ack ignored, pending dropped.
    idleInputs();
    step();
    checkMain("advance", 32'h508, 1, A8, 0, 0, 0);
    applyStimulus(mk(0, 0, 1, 'h900, 0, 0, 0, 0, 0, 0, 0, 0));
    step();
    checkMain("latch pend", 32'h508, 1, A8, 0, 0, 0);
    rst = 1'b1;
    applyStimulus(mk(0, 0, 0, 0, 0, 1, 32'hCAFEF00D, 0, 0, 0, 0, 0));
    step();
    checkMain("abort", 32'h0, 0, 32'h0, 0, 0, 0);
    rst = 1'b0;
    applyStimulus(mk(0, 0, 0, 0, 0, 1, 32'h0BADCAFE, 0, 0, 0, 0, 0));
    step();
    checkMain("reboot", 32'h0, 1, 32'h0, 0, 0, 0);
    checkOutput("wrap boot pc", wrapIf.pc_out, 32'hFFFF_FFFC);
    checkOutput("wrap boot req", {31'h0, wrapIf.imem_req}, 32'h1);
    step();
    checkMain("refetch", 32'h0, 0, 32'h0BADCAFE, 1, 0, 0);
    checkOutput("wrap instr", wrapIf.instr, 32'h0BADCAFE);
    checkOutput("wrap valid", {31'h0, wrapIf.instr_valid}, 32'h1);
    checkOutput("wrap hold pc", wrapIf.pc_out, 32'hFFFF_FFFC);
    step();
    checkMain("after refetch", 32'h4, 1, 32'h0BADCAFE, 0, 0, 0);
    checkOutput("wrap next pc", wrapIf.pc_out, 32'h0000_0000);
    checkOutput("wrap next valid", {31'h0, wrapIf.instr_valid}, 32'h0);

    // Faulty adder for one cycle while PC is parked in S_REQ.
    applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    add4Bad = 1'b1;
    step();
    checkMain("add4 bad", 32'h4, 1, 32'h0BADCAFE, 0, 0, EXP_ERR);
    add4Bad = 1'b0;
    step();
    checkMain("add4 sticky1", 32'h4, 1, 32'h0BADCAFE, 0, 0, EXP_ERR);
    step();
    checkMain("add4 sticky2", 32'h4, 1, 32'h0BADCAFE, 0, 0, EXP_ERR);
    rst = 1'b1;
    step();
    checkMain("add4 cleared", 32'h0, 0, 32'h0, 0, 0, 0);
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Program-counter register and instruction-fetch sequencer.
- Drives the current PC into ADD4 operand A and takes ADD4's RES back as the sequential next PC.
- Redirects on jump or branch, issues one-outstanding requests to instruction memory, and holds the fetched instruction for decode until it is accepted.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  synchronous, active-high reset.
- PC_PLUS4  in  32  ADD4 RES, i.e. PC_OUT+4.
- PC_OUT  out  32  current PC; feeds ADD4 A and the imem address.
- JMP  in  1  jump redirect request.
- JMP_TARGET  in  32  jump destination.
- BR_TAKEN  in  1  branch redirect request.
- BR_TARGET  in  32  branch destination.
- STALL  in  1  decode not ready; hold the current instruction.
- IMEM_REQ  out  1  fetch request for address PC_OUT.
- IMEM_ACK  in  1  imem returns data this cycle.
- IMEM_RDATA  in  32  instruction word, valid with IMEM_ACK.
- INSTR  out  32  held instruction.
- INSTR_VALID  out  1  INSTR valid for PC_OUT.
- MISALIGN  out  1  one-cycle pulse when a redirect target has bits [1:0]!=0.
- ADD4_ERR  out  1  sticky adder-check error (see Optional Feature).

Behaviour:
- Interface: one clock CLK; RST is synchronous and active-high. All outputs are registered.
- Reset values:
  - PC_OUT=RESET_PC.
  - IMEM_REQ=0, INSTR=0, INSTR_VALID=0, MISALIGN=0, ADD4_ERR=0.
  - State=S_BOOT; pending redirect cleared.
- RST overrides everything. Asserting it mid-request aborts the request, and any IMEM_ACK while RST=1 is ignored.
- Redirect selection:
  - JMP beats BR_TAKEN; a redirect beats STALL.
  - The selected target has bits [1:0] forced to 00; if either bit was set, MISALIGN=1 the next cycle.
- FSM:
  - S_BOOT: IMEM_REQ=0; goes to S_REQ after 1 cycle.
  - S_REQ: IMEM_REQ=1 and PC_OUT stable.
    - A redirect without ACK is latched into the pending register; a later redirect overwrites it.
    - ACK with no redirect this cycle and none pending: INSTR<=IMEM_RDATA, INSTR_VALID<=1, go to S_HOLD.
    - ACK with a redirect this cycle or pending: discard data, PC_OUT<=target (this-cycle redirect beats pending), clear pending, stay in S_REQ (new request next cycle).
  - S_HOLD: INSTR_VALID=1 and IMEM_REQ=0.
    - Redirect: PC_OUT<=target, INSTR_VALID<=0, go to S_REQ.
    - Else if !STALL: PC_OUT<=PC_PLUS4, INSTR_VALID<=0, go to S_REQ.
    - Else hold all state.
- Throughput: with a zero-wait imem (ACK in the first S_REQ cycle), one instruction every 2 cycles.
- Wrap-around: PC 0xFFFFFFFC advances to 0x00000000 through PC_PLUS4 with no special handling.
- PC_PLUS4 is sampled only in S_HOLD on advance. The block never adds internally in the datapath.

Optional Feature:
- Macro PC_CHECK_EN.
  - Defined: each cycle, compare PC_PLUS4 with an internal PC_OUT+32'd4 (mod 2^32). A mismatch sets ADD4_ERR=1 on the next edge, and it stays set until RST.
  - Undefined: ADD4_ERR is tied to 0 and no checker logic is built.
- Fetch behaviour is identical either way.

Test Plan:
- Reset, then release, with a zero-wait imem (ACK=1, RDATA=0x20080005) and a correct ADD4 model → PC_OUT 0x0 in S_BOOT; IMEM_REQ=1 next cycle; INSTR=0x20080005, VALID=1 one cycle later; PC_OUT=0x4 the cycle after that.
- STALL=1 for 3 cycles in S_HOLD at PC 0x8 → PC_OUT stays 0x8, INSTR and VALID held; STALL=0 → PC_OUT=0xC, VALID=0.
- JMP=1, JMP_TARGET=0x100 with BR_TAKEN=1, BR_TARGET=0x40 the same cycle in S_HOLD → PC_OUT=0x100, MISALIGN=0. Then JMP_TARGET=0x103 → PC_OUT=0x100, MISALIGN pulses 1 cycle.
- BR_TAKEN=1, BR_TARGET=0x80 while in S_REQ with ACK delayed 3 cycles → arriving RDATA discarded, VALID stays 0, next request at PC_OUT=0x80.
- RESET_PC=0xFFFFFFFC, ADD4 model wraps → first instruction at 0xFFFFFFFC, next PC_OUT=0x00000000.
- PC_CHECK_EN defined, ADD4 model forced to return PC+8 → ADD4_ERR=1 one cycle later and stays 1 until RST. Same run without the macro → ADD4_ERR stays 0.
